// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 slave giving a master access to a small 8-bit register file
module spi_slave_regfile #(
    parameter int ADDR_BITS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Mclk,
    input  logic                 nReset,
    input  logic                 SPI_clk,
    input  logic                 SPI_CS,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic                 Wr_Strobe,
    output logic [6:0]           Wr_Addr,
    output logic [7:0]           Wr_Data,
    output logic                 Busy,
    input  logic [ADDR_BITS-1:0] Reg_Sel,
    output logic [7:0]           Reg_Data
);

    localparam int NREGS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync, sync_valid;
    logic       sck_s, cs_s, mosi_s;
    logic       sck_prev, cs_prev, armed;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic [6:0] addr_cnt;
    logic [7:0] tx_sr;
    logic       rd_pending;
    logic       byte_done, wr_fire, wr_in_range;
    logic [6:0] rd_addr;
    logic [7:0] rd_byte;
    logic [7:0] regs [NREGS];

    assign sck_s  = clk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // armed stays low after reset until a genuine, flushed CS-high has been seen
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            clk_sync   <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sync_valid <= '0;
            sck_prev   <= 1'b0;
            cs_prev    <= 1'b1;
            armed      <= 1'b0;
        end else begin
            clk_sync[0]   <= SPI_clk;
            cs_sync[0]    <= SPI_CS;
            mosi_sync[0]  <= SPI_MOSI;
            sync_valid[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]   <= clk_sync[i-1];
                cs_sync[i]    <= cs_sync[i-1];
                mosi_sync[i]  <= mosi_sync[i-1];
                sync_valid[i] <= sync_valid[i-1];
            end
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
            if (sync_valid[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = armed & cs_prev & ~cs_s;
    assign rx_byte   = {rx_sr, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign wr_fire   = (state == WRITE) && byte_done && !cs_rise;
    assign wr_in_range = int'(addr_cnt) < NREGS;

    // in ADDR the read address is the byte completing this cycle, later it is the counter
    assign rd_addr = (state == ADDR) ? rx_byte[6:0] : addr_cnt;
    assign rd_byte = (int'(rd_addr) < NREGS) ? regs[rd_addr[ADDR_BITS-1:0]] : 8'h00;

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (cs_fall) state_nxt = ADDR;
            ADDR:        if (cs_rise) state_nxt = IDLE;
                         else if (byte_done) state_nxt = rx_byte[7] ? READ : WRITE;
            WRITE, READ: if (cs_rise) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        SPI_MISO = (state == READ) ? tx_sr[7] : 1'b0;
        Busy     = (state != IDLE);
    end

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            bit_cnt    <= 3'd0;
            rx_sr      <= 7'd0;
            addr_cnt   <= 7'd0;
            tx_sr      <= 8'd0;
            rd_pending <= 1'b0;
            Wr_Strobe  <= 1'b0;
            Wr_Addr    <= 7'd0;
            Wr_Data    <= 8'd0;
        end else begin
            Wr_Strobe <= 1'b0;
            if (cs_rise) begin
                bit_cnt    <= 3'd0;
                rd_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) bit_cnt <= 3'd0;
                    ADDR, WRITE: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    addr_cnt   <= rx_byte[6:0];
                                    tx_sr      <= rd_byte;
                                    rd_pending <= 1'b0;
                                end else begin
                                    Wr_Strobe <= 1'b1;
                                    Wr_Addr   <= addr_cnt;
                                    Wr_Data   <= rx_byte;
                                    addr_cnt  <= addr_cnt + 7'd1;
                                end
                            end
                        end
                    end
                    READ: begin
                        // the falling edge closing the address byte must not shift out the MSB
                        if (sck_rise) begin
                            bit_cnt    <= bit_cnt + 3'd1;
                            rd_pending <= 1'b1;
                            if (bit_cnt == 3'd7)
                                addr_cnt <= addr_cnt + 7'd1;
                        end else if (sck_fall && rd_pending) begin
                            rd_pending <= 1'b0;
                            if (bit_cnt == 3'd0)
                                tx_sr <= rd_byte;
                            else
                                tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= 8'h00;
        end else if (wr_fire && wr_in_range) begin
            regs[addr_cnt[ADDR_BITS-1:0]] <= rx_byte;
        end
    end

    assign Reg_Data = regs[Reg_Sel];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - self-checking bench for spi_slave_regfile
`timescale 1ns/1ps
module tb_spi_slave_regfile;

    localparam int HP = 80;

    logic       Mclk = 1'b0;
    logic       nReset = 1'b0;
    logic       SPI_clk = 1'b0;
    logic       SPI_CS = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic [3:0] Reg_Sel = 4'd0;
    logic       SPI_MISO, Wr_Strobe, Busy;
    logic [6:0] Wr_Addr;
    logic [7:0] Wr_Data, Reg_Data;

    spi_slave_regfile #(.ADDR_BITS(4), .SYNC_STAGES(2)) dut (
        .Mclk(Mclk), .nReset(nReset), .SPI_clk(SPI_clk), .SPI_CS(SPI_CS),
        .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .Wr_Strobe(Wr_Strobe),
        .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Busy(Busy),
        .Reg_Sel(Reg_Sel), .Reg_Data(Reg_Data)
    );

    always #5 Mclk = ~Mclk;

    int tests = 0;
    int fails = 0;

    logic [6:0] sq_addr[$];
    logic [7:0] sq_data[$];
    logic [6:0] e_addr[$];
    logic [7:0] e_data[$];
    logic [7:0] mdl [16];
    logic       prev_strobe = 1'b0;
    int         wide_pulse = 0;
    logic [7:0] prev_rd = 8'h00;
    logic [7:0] cap_before = 8'hxx;
    logic [7:0] cap_after = 8'hxx;

    always @(negedge Mclk) begin
        if (Wr_Strobe) begin
            sq_addr.push_back(Wr_Addr);
            sq_data.push_back(Wr_Data);
            if (Wr_Addr < 7'd16 && Wr_Addr[3:0] == Reg_Sel) begin
                cap_before = prev_rd;
                cap_after  = Reg_Data;
            end
            if (prev_strobe) wide_pulse++;
        end
        prev_strobe = Wr_Strobe;
        prev_rd     = Reg_Data;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] rb);
        rb = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_MOSI = b[i];
            #HP;
            rb[i] = SPI_MISO;
            SPI_clk = 1'b1;
            #HP;
            SPI_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        SPI_CS = 1'b0;
        #HP;
    endtask

    task automatic cs_end();
        #HP;
        SPI_CS = 1'b1;
        #200;
    endtask

    task automatic do_xact(input logic rw, input logic [6:0] a, input int n, input logic [31:0] d,
                           output logic [31:0] rd, output logic [7:0] rb_addr, output logic busy_mid);
        logic [7:0] b;
        sq_addr.delete();
        sq_data.delete();
        rd = 32'h0;
        cs_begin();
        xfer_bits({rw, a}, 8, rb_addr);
        busy_mid = Busy;
        for (int k = 0; k < n; k++) begin
            xfer_bits(d[31-8*k -: 8], 8, b);
            rd[31-8*k -: 8] = b;
        end
        cs_end();
    endtask

    // Reference: a write stores each byte at a rising address, a read returns the
    // register at each rising address, out-of-range reads as 0; address wraps mod 128.
    task automatic model_xact(input logic rw, input logic [6:0] a, input int n, input logic [31:0] d,
                              output logic [31:0] exp_rd);
        int addr = a;
        e_addr.delete();
        e_data.delete();
        exp_rd = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (rw) begin
                exp_rd[31-8*k -: 8] = (addr < 16) ? mdl[addr] : 8'h00;
            end else begin
                e_addr.push_back(7'(addr));
                e_data.push_back(d[31-8*k -: 8]);
                if (addr < 16) mdl[addr] = d[31-8*k -: 8];
            end
            addr = (addr + 1) % 128;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            Reg_Sel = 4'(i);
            #1;
            check($sformatf("%s reg[%0d]", tag, i), {24'h0, Reg_Data}, {24'h0, mdl[i]});
        end
        Reg_Sel = 4'd3;
    endtask

    task automatic run_and_check(input string tag, input logic rw, input logic [6:0] a,
                                 input int n, input logic [31:0] d, output logic [31:0] rd,
                                 output int nstrobes);
        logic [31:0] exp_rd;
        logic [7:0]  rb_addr;
        logic        busy_mid;
        model_xact(rw, a, n, d, exp_rd);
        do_xact(rw, a, n, d, rd, rb_addr, busy_mid);
        nstrobes = sq_addr.size();
        check({tag, " miso_in_addr"}, {24'h0, rb_addr}, 32'h0);
        check({tag, " busy_mid"}, {31'h0, busy_mid}, 32'h1);
        check({tag, " busy_after"}, {31'h0, Busy}, 32'h0);
        check({tag, " strobe_count"}, sq_addr.size(), e_addr.size());
        for (int k = 0; k < e_addr.size() && k < sq_addr.size(); k++) begin
            check($sformatf("%s strobe%0d_addr", tag, k), {25'h0, sq_addr[k]}, {25'h0, e_addr[k]});
            check($sformatf("%s strobe%0d_data", tag, k), {24'h0, sq_data[k]}, {24'h0, e_data[k]});
        end
        if (rw) check({tag, " read_data"}, rd, exp_rd);
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        int          n;
        logic [31:0] d;
        int          exp_strobes;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] rd;
        logic [7:0]  rb;
        int          ns;

        vecs[0] = '{1'b0, 7'h03, 1, 32'hA500_0000, 1, 32'h0};
        vecs[1] = '{1'b1, 7'h03, 1, 32'h0000_0000, 0, 32'hA500_0000};
        vecs[2] = '{1'b0, 7'h0E, 3, 32'h1122_3300, 3, 32'h0};
        vecs[3] = '{1'b1, 7'h0E, 2, 32'h0000_0000, 0, 32'h1122_0000};
        vecs[4] = '{1'b0, 7'h00, 1, 32'h5A00_0000, 1, 32'h0};
        vecs[5] = '{1'b1, 7'h7F, 2, 32'h0000_0000, 0, 32'h005A_0000};

        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        Reg_Sel = 4'd3;
        #33;
        @(negedge Mclk);
        check("reset busy", {31'h0, Busy}, 32'h0);
        check("reset miso", {31'h0, SPI_MISO}, 32'h0);
        check("reset strobe", {31'h0, Wr_Strobe}, 32'h0);
        check("reset wr_addr", {25'h0, Wr_Addr}, 32'h0);
        check("reset wr_data", {24'h0, Wr_Data}, 32'h0);
        check_regs("reset");
        nReset = 1'b1;
        #200;
        @(negedge Mclk);

        for (int v = 0; v < 6; v++) begin
            run_and_check($sformatf("vec%0d", v), vecs[v].rw, vecs[v].addr, vecs[v].n, vecs[v].d, rd, ns);
            check($sformatf("vec%0d table_strobes", v), ns, vecs[v].exp_strobes);
            if (vecs[v].rw) check($sformatf("vec%0d table_read", v), rd, vecs[v].exp_rd);
            if (v == 0) begin
                check("same_cycle old_value", {24'h0, cap_before}, 32'h00);
                check("same_cycle new_value", {24'h0, cap_after}, 32'hA5);
            end
            if (v == 2) check("vec2 third_strobe_addr", (sq_addr.size() == 3) ? {25'h0, sq_addr[2]} : 32'hFFFF, 32'h10);
            check_regs($sformatf("vec%0d", v));
        end

        // partial byte then CS rise: discarded
        sq_addr.delete();
        cs_begin();
        xfer_bits(8'h05, 8, rb);
        xfer_bits(8'hFF, 5, rb);
        cs_end();
        check("partial strobes", sq_addr.size(), 0);
        check("partial busy", {31'h0, Busy}, 32'h0);
        Reg_Sel = 4'd5;
        #1;
        check("partial reg5", {24'h0, Reg_Data}, 32'h00);
        run_and_check("after_partial", 1'b0, 7'h05, 1, 32'h3C00_0000, rd, ns);
        check_regs("after_partial");

        // reset 12 clocks into a write, released while CS is still low
        cs_begin();
        xfer_bits(8'h01, 8, rb);
        xfer_bits(8'hFF, 4, rb);
        nReset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        check("midrst busy", {31'h0, Busy}, 32'h0);
        check("midrst miso", {31'h0, SPI_MISO}, 32'h0);
        check("midrst strobe", {31'h0, Wr_Strobe}, 32'h0);
        check("midrst wr_addr", {25'h0, Wr_Addr}, 32'h0);
        check("midrst wr_data", {24'h0, Wr_Data}, 32'h0);
        check_regs("midrst");
        #99;
        nReset = 1'b1;
        sq_addr.delete();
        #HP;
        xfer_bits(8'h02, 8, rb);
        xfer_bits(8'h55, 8, rb);
        #HP;
        check("post_rst ignored_busy", {31'h0, Busy}, 32'h0);
        check("post_rst ignored_strobes", sq_addr.size(), 0);
        SPI_CS = 1'b1;
        #200;
        check_regs("post_rst ignored");
        run_and_check("post_rst", 1'b0, 7'h01, 1, 32'h7E00_0000, rd, ns);
        check_regs("post_rst");

        for (int t = 0; t < 20; t++) begin
            logic       rw;
            logic [6:0] a;
            int         n;
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = 7'($urandom_range(0, 15));
                1:       a = 7'($urandom_range(124, 127));
                default: a = 7'($urandom_range(0, 127));
            endcase
            n = $urandom_range(1, 4);
            run_and_check($sformatf("rand%0d", t), rw, a, n, $urandom, rd, ns);
        end
        check_regs("rand_end");
        check("strobe_width", wide_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
